// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: fetch -> decode -> execute -> write-back sequencing for an
// 8-bit ALU and register file, with PC advance and illegal-opcode detection.
module cpu_control_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned REG_AW  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  output logic              instr_req,
  output logic [PC_W-1:0]   pc,
  output logic [REG_AW-1:0] readreg1,
  output logic [REG_AW-1:0] readreg2,
  output logic [REG_AW-1:0] writereg,
  output logic              writeenable,
  output logic [2:0]        aluop,
  output logic              complement,
  output logic              imm_sel,
  output logic [7:0]        immediate,
  output logic              busy,
  output logic              illegal
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetch     = 3'd1;
  localparam logic [2:0] StDecode    = 3'd2;
  localparam logic [2:0] StExecute   = 3'd3;
  localparam logic [2:0] StWriteback = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     instr_q;

  logic [7:0] opcode;
  logic [2:0] dec_aluop;
  logic       dec_comp;
  logic       dec_imm;
  logic       dec_legal;
  logic       active;

  // Upper address bits of DEST/SRC1 are deliberately ignored.
  logic unused_fields;
  assign unused_fields = ^{instr_q[23:16+REG_AW], instr_q[15:8+REG_AW]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (enable) state_d = StFetch;
      StFetch:     if (instr_valid) state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = enable ? StFetch : StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && instr_valid) instr_q <= instruction;
      if (state_q == StWriteback) pc_q <= pc_q + PC_W'(PC_STEP);
    end
  end

  assign opcode = instr_q[31:24];

  always_comb begin
    dec_aluop = 3'b000;
    dec_comp  = 1'b0;
    dec_imm   = 1'b0;
    dec_legal = 1'b1;
    case (opcode)
      8'h00: dec_imm = 1'b1;
      8'h01: dec_aluop = 3'b000;
      8'h02: dec_aluop = 3'b001;
      8'h03: begin
        dec_aluop = 3'b001;
        dec_comp  = 1'b1;
      end
      8'h04: dec_aluop = 3'b010;
      8'h05: dec_aluop = 3'b011;
      default: dec_legal = 1'b0;
    endcase
  end

  assign active = (state_q == StDecode) || (state_q == StExecute) ||
                  (state_q == StWriteback);

  always_comb begin
    instr_req   = (state_q == StFetch);
    pc          = pc_q;
    busy        = (state_q != StIdle);
    readreg1    = active ? instr_q[8 +: REG_AW]  : '0;
    readreg2    = active ? instr_q[0 +: REG_AW]  : '0;
    writereg    = active ? instr_q[16 +: REG_AW] : '0;
    immediate   = active ? instr_q[7:0]          : 8'h00;
    aluop       = active ? dec_aluop             : 3'b000;
    complement  = active && dec_comp;
    imm_sel     = active && dec_imm;
    illegal     = (state_q == StDecode) && !dec_legal;
    // Gated by reset so a reset landing on write-back suppresses the register write.
    writeenable = (state_q == StWriteback) && dec_legal && reset_n;
  end

endmodule
